voice_tick_sched: RTL and testbench

- Per-sample scheduler driven by the standard-rate divider pulse (10 kHz domain clock, one-cycle pulse per sample period).
- On each tick, sequences the enabled voice channels one at a time onto the single shared sample-generator datapath using a req/ack handshake, then signals frame completion.
- Flags dropped ticks (overrun) and unresponsive generator (timeout).

---
 rtl/voice_tick_sched.sv | 120 ++++++++++++
 tb/tb_voice_tick_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_tick_sched.sv
// Per-sample voice scheduler: on each tick, walks the enabled voices in index order
// and hands each one to the shared sample generator through a req/ack handshake.
module voice_tick_sched #(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  tick,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic                  gen_req,
  output logic [VIDX_W-1:0]     gen_voice,
  input  logic                  gen_ack,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);
  localparam logic [VIDX_W-1:0] IDX_LAST = VIDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [VIDX_W-1:0]       idx, idx_n;
  logic [NUM_VOICES-1:0]   en_snap, en_snap_n;
  logic [TCNT_W-1:0]       tcnt, tcnt_n;
  logic                    overrun_n, timeout_err_n;
  logic                    leave;
  logic                    last;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      idx         <= '0;
      en_snap     <= '0;
      tcnt        <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      en_snap     <= en_snap_n;
      tcnt        <= tcnt_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_err_n;
    end
  end

  assign last = (idx == IDX_LAST);

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    en_snap_n     = en_snap;
    tcnt_n        = tcnt;
    leave         = 1'b0;
    overrun_n     = clr_err ? 1'b0 : overrun;
    timeout_err_n = clr_err ? 1'b0 : timeout_err;

    // A tick outside IDLE is dropped; setting beats a simultaneous clear.
    if (tick && (state != IDLE)) overrun_n = 1'b1;

    case (state)
      IDLE: begin
        if (tick) begin
          en_snap_n = voice_en;
          idx_n     = '0;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (en_snap[idx]) begin
          state_n = REQ;
          tcnt_n  = '0;
        end else if (last) begin
          state_n = DONE;
        end else begin
          idx_n = idx + VIDX_W'(1);
        end
      end
      REQ: begin
        if (gen_ack) begin
          leave = 1'b1;
        end else if (tcnt == TCNT_MAX) begin
          timeout_err_n = 1'b1;
          leave         = 1'b1;
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
        end
        // A timed-out voice counts as serviced, so the frame always moves on.
        if (leave) begin
          if (last) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + VIDX_W'(1);
            state_n = SCAN;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign gen_req    = (state == REQ);
  assign gen_voice  = gen_req ? idx : '0;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_voice_tick_sched.sv
// Bench for voice_tick_sched: each frame's expected request windows are computed
// up front from the enable mask and per-voice ack latency, then checked cycle by cycle.
module tb_voice_tick_sched;

  localparam int NV = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          tick = 1'b0;
  logic [NV-1:0] voice_en = '0;
  logic          gen_req;
  logic [1:0]    gen_voice;
  logic          gen_ack = 1'b0;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          timeout_err;
  logic          clr_err = 1'b0;

  voice_tick_sched #(.NUM_VOICES(NV), .VIDX_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .tick(tick), .voice_en(voice_en),
    .gen_req(gen_req), .gen_voice(gen_voice), .gen_ack(gen_ack),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model state
  int            lat [NV];
  logic [NV-1:0] m_en;
  int            m_lo [NV];
  int            m_hi [NV];
  logic          m_to [NV];
  int            m_done;
  logic          exp_ovr = 1'b0;
  logic          exp_to  = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic er, input int ev, input logic ed, input logic eb,
                               input logic chk_voice);
    check("gen_req", 8'(gen_req), 8'(er));
    if (chk_voice) check("gen_voice", 8'(gen_voice), 8'(ev));
    check("frame_done", 8'(frame_done), 8'(ed));
    check("busy", 8'(busy), 8'(eb));
    check("overrun", 8'(overrun), 8'(exp_ovr));
    check("timeout_err", 8'(timeout_err), 8'(exp_to));
  endtask

  // Frame timeline with the tick sampled at edge 0: voice scans start in cycle 1;
  // an enabled voice costs one scan cycle plus min(lat+1, TO) request cycles.
  task automatic build_model(input logic [NV-1:0] en);
    int c;
    int len;
    m_en = en;
    c = 1;
    for (int i = 0; i < NV; i++) begin
      if (en[i]) begin
        len     = (lat[i] >= TO) ? TO : lat[i] + 1;
        m_lo[i] = c + 1;
        m_hi[i] = c + len;
        m_to[i] = (lat[i] >= TO);
        c       = c + 1 + len;
      end else begin
        m_lo[i] = 0;
        m_hi[i] = -1;
        m_to[i] = 1'b0;
        c       = c + 1;
      end
    end
    m_done = c;
  endtask

  task automatic check_model(input int k);
    logic er;
    int   ev;
    er = 1'b0;
    ev = 0;
    for (int i = 0; i < NV; i++)
      if (k >= m_lo[i] && k <= m_hi[i]) begin
        er = 1'b1;
        ev = i;
      end
    check_outputs(er, ev, (k == m_done), (k >= 1 && k <= m_done), er);
  endtask

  // Driver: tick in cycle 0, then a latency-programmed generator responder.
  task automatic run_frame(input int ovr_cyc, input int clr_cyc, input int rst_cyc);
    int   age;
    logic prev_req;
    logic to_k;
    age = 0;
    prev_req = 1'b0;
    cyc = 0;
    voice_en = m_en;
    tick = 1'b1;
    gen_ack = 1'b0;
    clr_err = (clr_cyc == 0);
    if (clr_cyc == 0) begin
      exp_ovr = 1'b0;
      exp_to  = 1'b0;
    end
    step();
    tick = 1'b0;
    clr_err = 1'b0;
    for (int k = 1; k <= m_done + 1; k++) begin
      cyc = k;
      check_model(k);
      if (gen_req) begin
        age = prev_req ? age + 1 : 0;
        gen_ack = (age == lat[gen_voice]);
      end else begin
        age = 0;
        gen_ack = 1'($urandom_range(0, 1));
      end
      prev_req = gen_req;
      voice_en = NV'($urandom);
      tick     = (k == ovr_cyc);
      clr_err  = (k == clr_cyc);
      nrst     = !(k == rst_cyc);
      to_k = 1'b0;
      for (int i = 0; i < NV; i++)
        if (m_to[i] && k == m_hi[i]) to_k = 1'b1;
      if (k == rst_cyc) begin
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
      end else begin
        if (tick && k <= m_done) exp_ovr = 1'b1;
        else if (clr_err) exp_ovr = 1'b0;
        if (to_k) exp_to = 1'b1;
        else if (clr_err) exp_to = 1'b0;
      end
      step();
      tick = 1'b0;
      clr_err = 1'b0;
      gen_ack = 1'b0;
      nrst = 1'b1;
      if (k == rst_cyc) begin
        cyc = k + 1;
        check_outputs(1'b0, 0, 1'b0, 1'b0, 1'b1);
        return;
      end
    end
  endtask

  task automatic idle_cycles(input int n, input logic clr_first);
    for (int j = 0; j < n; j++) begin
      cyc = 100 + j;
      check_outputs(1'b0, 0, 1'b0, 1'b0, 1'b0);
      gen_ack = 1'($urandom_range(0, 1));
      clr_err = clr_first && (j == 0);
      if (clr_err) begin
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
      end
      step();
      clr_err = 1'b0;
      gen_ack = 1'b0;
    end
  endtask

  initial begin
    // reset
    nrst = 1'b0;
    step();
    step();
    cyc = -1;
    check_outputs(1'b0, 0, 1'b0, 1'b0, 1'b1);
    nrst = 1'b1;
    step();

    // all voices, immediate ack: REQ in 2,4,6,8, frame_done in 9
    for (int i = 0; i < NV; i++) lat[i] = 0;
    build_model(4'b1111);
    run_frame(-1, -1, -1);
    idle_cycles(2, 1'b0);

    // voices 1 and 3, ack 3 cycles after request
    for (int i = 0; i < NV; i++) lat[i] = 3;
    build_model(4'b1010);
    run_frame(-1, -1, -1);

    // nothing enabled: scan only, frame_done in cycle 5
    build_model(4'b0000);
    run_frame(-1, -1, -1);

    // generator never answers voice 0
    lat[0] = 99;
    build_model(4'b0001);
    run_frame(-1, -1, -1);
    idle_cycles(1, 1'b0);
    idle_cycles(2, 1'b1);

    // dropped tick during voice 2 request, then a clean frame
    for (int i = 0; i < NV; i++) lat[i] = $urandom_range(0, 3);
    build_model(4'b1111);
    run_frame(m_lo[2], -1, -1);
    build_model(4'b1111);
    run_frame(-1, -1, -1);
    // clear and new overrun in the same cycle: overrun stays set
    build_model(4'b1111);
    run_frame(3, 3, -1);
    idle_cycles(2, 1'b1);

    // reset while voice 1 is being requested
    for (int i = 0; i < NV; i++) lat[i] = 2;
    build_model(4'b1111);
    run_frame(-1, -1, m_lo[1]);
    idle_cycles(3, 1'b0);
    for (int i = 0; i < NV; i++) lat[i] = 0;
    build_model(4'b1111);
    run_frame(-1, -1, -1);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NV; i++)
        lat[i] = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      build_model(NV'($urandom));
      run_frame(($urandom_range(0, 2) == 0) ? $urandom_range(1, m_done) : -1,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, m_done + 1) : -1,
                -1);
      idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
